// File: rtl/pair_deserializer_pkg.sv
// Shared types and constants for the pair deserializer.
// Holds the FSM state enum and the symbol/stats widths.
package pair_deserializer_pkg;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam int SYM_W   = 2;
    localparam int STATS_W = 16;

endpackage

// File: rtl/pair_deser_and_reduce.sv
// Combinational AND-reduction over a word of width W.
// Feeds the O_all flag of pair_deserializer.
module pair_deser_and_reduce #(
    parameter int W = 8
) (
    input  logic [W-1:0] data_i,
    output logic         all_o
);

    // Every bit of the word set.
    assign all_o = &data_i;

endmodule

// File: rtl/pair_deserializer.sv
// Packs WORDS 2-bit symbols LSB-first into one output word.
// Optional macro PAIR_DESERIALIZER_STATS_EN adds a word_count output.
module pair_deserializer
    import pair_deserializer_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                     CLK,
    input  logic                     RESETN,
    input  logic [SYM_W-1:0]         I,
    input  logic                     I_valid,
    output logic                     I_ready,
    output logic [SYM_W*WORDS-1:0]   O,
    output logic                     O_valid,
    input  logic                     O_ready,
    output logic                     O_all
`ifdef PAIR_DESERIALIZER_STATS_EN
    ,
    output logic [STATS_W-1:0]       word_count
`endif
);

    localparam int OW = SYM_W * WORDS;
    localparam int CW = $clog2(WORDS) + 1;
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [OW-1:0]   o_q, o_d;
    logic            in_xfer;
    logic            out_xfer;
    logic            all_raw;

    assign O_valid  = (state_q == HOLD);
    assign I_ready  = (state_q == FILL) | O_ready;
    assign in_xfer  = I_valid & I_ready;
    assign out_xfer = O_valid & O_ready;
    assign O        = o_q;
    assign O_all    = all_raw & O_valid;

    pair_deser_and_reduce #(
        .W (OW)
    ) u_and (
        .data_i (o_q),
        .all_o  (all_raw)
    );

    // Slot writes, symbol counter and FILL/HOLD transitions.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        o_d     = o_q;
        unique case (state_q)
            FILL: begin
                if (in_xfer) begin
                    for (int k = 0; k < WORDS; k++) begin
                        if (cnt_q == CW'(k)) begin
                            o_d[SYM_W*k +: SYM_W] = I;
                        end
                    end
                    if (cnt_q == LAST) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            HOLD: begin
                if (out_xfer) begin
                    state_d = FILL;
                    if (in_xfer) begin
                        o_d[SYM_W-1:0] = I;
                        cnt_d          = CW'(1);
                    end else begin
                        cnt_d = '0;
                    end
                end
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q <= FILL;
            cnt_q   <= '0;
            o_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            o_q     <= o_d;
        end
    end

`ifdef PAIR_DESERIALIZER_STATS_EN
    logic [STATS_W-1:0] wc_q, wc_d;

    // Saturating count of output transfers.
    always_comb begin
        wc_d = wc_q;
        if (out_xfer && (wc_q != '1)) begin
            wc_d = wc_q + STATS_W'(1);
        end
    end

    // Counter register, cleared by reset.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            wc_q <= '0;
        end else begin
            wc_q <= wc_d;
        end
    end

    assign word_count = wc_q;
`endif

endmodule

// File: tb/tb_pair_deserializer.sv
// Directed and randomized-stall bench for pair_deserializer (WORDS=4).
// Inputs change on the falling edge; outputs are checked before the next rise.
module tb_pair_deserializer;

    logic       CLK = 1'b0;
    logic       RESETN;
    logic [1:0] I;
    logic       I_valid;
    logic       I_ready;
    logic [7:0] O;
    logic       O_valid;
    logic       O_ready;
    logic       O_all;
`ifdef PAIR_DESERIALIZER_STATS_EN
    logic [15:0] word_count;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    pair_deserializer #(
        .WORDS (4)
    ) dut (
        .CLK     (CLK),
        .RESETN  (RESETN),
        .I       (I),
        .I_valid (I_valid),
        .I_ready (I_ready),
        .O       (O),
        .O_valid (O_valid),
        .O_ready (O_ready),
        .O_all   (O_all)
`ifdef PAIR_DESERIALIZER_STATS_EN
        ,
        .word_count (word_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one symbol at the falling edge; it is taken at the next rise.
    task automatic send(input logic [1:0] s);
        @(negedge CLK);
        I       = s;
        I_valid = 1'b1;
    endtask

    task automatic idle_to_negedge();
        @(negedge CLK);
        I_valid = 1'b0;
        #1;
    endtask

    logic [1:0] sym [1000];
    logic [7:0] exp_w [250];
    logic [7:0] bb_w [3];
    logic [1:0] bb_s [12];
    int idx;
    int widx;
    int cyc;

    initial begin
        RESETN  = 1'b0;
        I       = 2'b00;
        I_valid = 1'b0;
        O_ready = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_ovalid", 32'(O_valid), 32'd0);
        chk("rst_o", 32'(O), 32'h00);
        chk("rst_oall", 32'(O_all), 32'd0);
        RESETN = 1'b1;
        #1;
        chk("rst_iready", 32'(I_ready), 32'd1);

        // Basic word with downstream stalled.
        send(2'b01);
        send(2'b10);
        send(2'b11);
        send(2'b00);
        idle_to_negedge();
        chk("w1_ovalid", 32'(O_valid), 32'd1);
        chk("w1_o", 32'(O), 32'h39);
        chk("w1_iready", 32'(I_ready), 32'd0);
        chk("w1_oall", 32'(O_all), 32'd0);
        // A blocked symbol must not disturb the held word.
        I       = 2'b11;
        I_valid = 1'b1;
        @(negedge CLK);
        #1;
        chk("w1_stall_o", 32'(O), 32'h39);
        chk("w1_stall_ovalid", 32'(O_valid), 32'd1);
        I_valid = 1'b0;
        O_ready = 1'b1;
        @(negedge CLK);
        #1;
        chk("w1_drain_ovalid", 32'(O_valid), 32'd0);
        chk("w1_drain_iready", 32'(I_ready), 32'd1);

        // All-ones word, single-cycle valid.
        repeat (4) send(2'b11);
        idle_to_negedge();
        chk("w2_o", 32'(O), 32'hFF);
        chk("w2_oall", 32'(O_all), 32'd1);
        chk("w2_ovalid", 32'(O_valid), 32'd1);
        @(negedge CLK);
        #1;
        chk("w2_ovalid_drop", 32'(O_valid), 32'd0);
        chk("w2_iready", 32'(I_ready), 32'd1);
        chk("w2_oall_masked", 32'(O_all), 32'd0);

        // Back-to-back words with slot-0 write during HOLD.
        bb_s = '{2'b00, 2'b01, 2'b10, 2'b11,
                 2'b11, 2'b11, 2'b00, 2'b00,
                 2'b10, 2'b10, 2'b10, 2'b01};
        bb_w = '{8'hE4, 8'h0F, 8'h6A};
        for (int k = 0; k < 12; k++) begin
            @(negedge CLK);
            #1;
            if (k > 0 && (k % 4) == 0) begin
                chk("bb_ovalid", 32'(O_valid), 32'd1);
                chk("bb_word", 32'(O), 32'(bb_w[k/4-1]));
            end else if (k > 0) begin
                chk("bb_fill_ovalid", 32'(O_valid), 32'd0);
            end
            chk("bb_iready", 32'(I_ready), 32'd1);
            I       = bb_s[k];
            I_valid = 1'b1;
        end
        idle_to_negedge();
        chk("bb_last_ovalid", 32'(O_valid), 32'd1);
        chk("bb_last_word", 32'(O), 32'(bb_w[2]));
        @(negedge CLK);
        #1;
        chk("bb_end_ovalid", 32'(O_valid), 32'd0);

        // Reset mid-word discards the partial symbols.
        O_ready = 1'b0;
        send(2'b01);
        send(2'b01);
        @(negedge CLK);
        I_valid = 1'b0;
        RESETN  = 1'b0;
        @(negedge CLK);
        #1;
        chk("mid_rst_o", 32'(O), 32'h00);
        RESETN = 1'b1;
        repeat (4) send(2'b10);
        idle_to_negedge();
        chk("mid_rst_word", 32'(O), 32'hAA);
        chk("mid_rst_ovalid", 32'(O_valid), 32'd1);

        // Reset while holding a word.
        RESETN = 1'b0;
        @(negedge CLK);
        #1;
        chk("hold_rst_ovalid", 32'(O_valid), 32'd0);
        chk("hold_rst_o", 32'(O), 32'h00);
        RESETN = 1'b1;
        send(2'b11);
        send(2'b01);
        send(2'b00);
        send(2'b10);
        idle_to_negedge();
        chk("post_rst_word", 32'(O), 32'h87);

`ifdef PAIR_DESERIALIZER_STATS_EN
        chk("stats_cnt", 32'(word_count), 32'd0);
        O_ready = 1'b1;
        @(negedge CLK);
        #1;
        chk("stats_one", 32'(word_count), 32'd1);
`endif

        // Random stalls against an LSB-first packing model.
        O_ready = 1'b1;
        @(negedge CLK);
        for (int k = 0; k < 1000; k++) begin
            sym[k] = 2'($urandom_range(0, 3));
        end
        for (int w = 0; w < 250; w++) begin
            exp_w[w] = {sym[4*w+3], sym[4*w+2], sym[4*w+1], sym[4*w]};
        end
        idx  = 0;
        widx = 0;
        cyc  = 0;
        while (widx < 250 && cyc < 20000) begin
            @(negedge CLK);
            cyc++;
            I_valid = (idx < 1000) && ($urandom_range(0, 3) != 0);
            I       = sym[idx < 1000 ? idx : 999];
            O_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (O_valid && O_ready) begin
                chk("rand_word", 32'(O), 32'(exp_w[widx]));
                widx++;
            end
            if (I_valid && I_ready) idx++;
        end
        chk("rand_words_seen", 32'(widx), 32'd250);
        I_valid = 1'b0;
        O_ready = 1'b0;
        @(negedge CLK);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
